psram_pattern_tester: RTL

Self-checking PSRAM exerciser that sits between a control source (button/UART/debug) and the existing `PsramController`. It drives the controller's `read`/`write`/`byte_write`/`addr`/`din` request interface and fills a configurable address range with one of four data patterns. It then reads the range back, verifies it, and reports pass/fail, the first failing location, a saturating error count and per-access latency-class counters. It is the parametrised successor of the board-level memory test. Byte or word granularity, pattern, range, stop-on-error policy and timeouts are all selectable, so the same block serves every PSRAM speed/latency build.

---
 rtl/psram_pattern_tester.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/psram_pattern_tester.sv
// PSRAM exerciser: writes a pattern over a range, reads it back, verifies.
// Reports the first failure, an error count and latency-class counters.
module psram_pattern_tester #(
  parameter int ADDR_W        = 22,
  parameter int BYTES         = 4194304,
  parameter int LATENCY       = 3,
  parameter int CNT_W         = 24,
  parameter int STOP_ON_ERROR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              word_mode,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy,
  output logic [3:0]        state,
  output logic              done,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       fail_expected,
  output logic [15:0]       fail_actual,
  output logic [CNT_W-1:0]  write_1x,
  output logic [CNT_W-1:0]  write_2x,
  output logic [CNT_W-1:0]  read_1x,
  output logic [CNT_W-1:0]  read_2x
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_INIT  = 4'd1;
  localparam logic [3:0] S_WRITE = 4'd2;
  localparam logic [3:0] S_READ  = 4'd3;
  localparam logic [3:0] S_DONE  = 4'd4;
  localparam logic [3:0] S_FAIL  = 4'd5;

  localparam int CYC_W = 17;
  localparam logic [CYC_W-1:0] INIT_TO = CYC_W'(65535);
  localparam logic [CYC_W-1:0] WR_TO   = CYC_W'(5 + 2 * LATENCY);
  localparam logic [CYC_W-1:0] RD_TO   = CYC_W'(10 + 2 * LATENCY);
  localparam logic [CYC_W-1:0] WR_1X   = CYC_W'(4 + LATENCY);
  localparam logic [CYC_W-1:0] RD_1X   = CYC_W'(10 + LATENCY);
  localparam logic [ADDR_W-1:0] LAST_B = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(BYTES - 2);

  logic [3:0]        st;
  logic [1:0]        md;
  logic              wm;
  logic              act;
  logic [CYC_W-1:0]  cyc;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic              is_last;

  logic              is_wr;
  logic              is_rd;
  logic              req;
  logic              cmpl;
  logic              mis;
  logic              to_hit;
  logic [7:0]        p_lo;
  logic [7:0]        p_hi;
  logic [15:0]       exp16;
  logic [15:0]       act16;

  function automatic logic [7:0] pat(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a
  );
    logic [21:0] x;
    logic [7:0]  h;
    x = 22'(a);
    h = x[7:0] ^ x[15:8] ^ {2'b00, x[21:16]} ^ 8'hC3;
    case (m)
      2'd0:    return h;
      2'd1:    return x[7:0];
      2'd2:    return 8'h01 << x[2:0];
      default: return ~h;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    is_wr  = (st == S_WRITE);
    is_rd  = (st == S_READ);
    req    = act && (cyc == '0);
    p_lo   = pat(md, addr);
    p_hi   = pat(md, {addr[ADDR_W-1:1], 1'b1});
    exp16  = wm ? {p_hi, p_lo} : {8'h00, p_lo};
    act16  = wm ? mem_dout
                : {8'h00, addr[0] ? mem_dout[15:8] : mem_dout[7:0]};
    cmpl   = act && (cyc != '0) && !mem_busy;
    mis    = is_rd && cmpl && (act16 != exp16);
    to_hit = act && !cmpl && (cyc == (is_wr ? WR_TO : RD_TO));
  end

  assign mem_write      = is_wr && req;
  assign mem_read       = is_rd && req;
  assign mem_byte_write = mem_write && !wm;
  assign mem_addr       = addr;
  // {p,p} in byte mode lets the controller pick either lane by addr[0]
  assign mem_din        = mem_write
                        ? (wm ? {p_hi, p_lo} : {p_lo, p_lo})
                        : 16'h0000;
  assign state          = st;
  assign done           = (st == S_DONE);
  assign fail           = (st == S_FAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= S_IDLE;
      md            <= '0;
      wm            <= 1'b0;
      act           <= 1'b0;
      cyc           <= '0;
      addr          <= '0;
      addr_nxt      <= '0;
      is_last       <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      write_1x      <= '0;
      write_2x      <= '0;
      read_1x       <= '0;
      read_2x       <= '0;
    end else begin
      // next address and end test registered off the critical path
      addr_nxt <= addr + {{(ADDR_W-2){1'b0}}, wm, ~wm};
      is_last  <= (addr == (wm ? LAST_W : LAST_B));
      case (st)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            md            <= mode;
            wm            <= word_mode;
            addr          <= '0;
            cyc           <= '0;
            act           <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            write_1x      <= '0;
            write_2x      <= '0;
            read_1x       <= '0;
            read_2x       <= '0;
            st            <= S_INIT;
          end
        end
        S_INIT: begin
          if (!mem_busy) begin
            cyc <= '0;
            act <= 1'b0;
            st  <= S_WRITE;
          end else if (cyc == INIT_TO) begin
            timeout   <= 1'b1;
            fail_addr <= addr;
            st        <= S_FAIL;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_WRITE, S_READ: begin
          if (!act) begin
            act <= 1'b1;
            cyc <= '0;
          end else if (cmpl) begin
            act  <= 1'b0;
            cyc  <= '0;
            addr <= addr_nxt;
            if (is_wr) begin
              if (cyc > WR_1X) write_2x <= sat_inc(write_2x);
              else             write_1x <= sat_inc(write_1x);
            end else begin
              if (cyc > RD_1X) read_2x <= sat_inc(read_2x);
              else             read_1x <= sat_inc(read_1x);
            end
            if (mis) begin
              err_count <= sat_inc(err_count);
              if (err_count == '0) begin
                fail_addr     <= addr;
                fail_expected <= exp16;
                fail_actual   <= act16;
              end
            end
            if (mis && (STOP_ON_ERROR != 0)) begin
              st <= S_FAIL;
            end else if (is_last) begin
              if (is_wr) begin
                addr <= '0;
                st   <= S_READ;
              end else begin
                st <= (mis || (err_count != '0)) ? S_FAIL : S_DONE;
              end
            end
          end else if (to_hit) begin
            act       <= 1'b0;
            timeout   <= 1'b1;
            fail_addr <= addr;
            st        <= S_FAIL;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
